// File: rtl/charge_pkg.sv
// Shared types and helpers for the charge-time countdown controller.
package charge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2,
        SLEEP = 2'd3
    } state_t;

    localparam logic [15:0] BCD_ZERO = 16'h0000;

    // True when every nibble of a 4-digit BCD word is a legal decimal digit.
    function automatic logic bcd_valid(input logic [15:0] value);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_down4.sv
// Four-digit BCD down-counter register: synchronous load, decrement with
// borrow across digits, and a zero flag.
module bcd_down4 (
    input  logic        clk,
    input  logic        rd,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic [15:0] value,
    output logic        zero
);

    // step[i]: digit i moves down this cycle (all lower digits are 0 and borrow).
    logic [3:0] step;

    // Borrow chain written out flat so no digit depends on another step bit.
    always_comb begin
        step[0] = dec;
        step[1] = dec && (value[3:0] == 4'd0);
        step[2] = dec && (value[7:0] == 8'd0);
        step[3] = dec && (value[11:0] == 12'd0);
    end

    // Digit register: load wins over decrement; a digit at 0 wraps to 9.
    always_ff @(posedge clk or negedge rd) begin
        if (!rd) begin
            value <= 16'h0000;
        end else if (load) begin
            value <= load_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (step[i]) begin
                    value[4*i +: 4] <= (value[4*i +: 4] == 4'd0) ? 4'd9
                                                                : value[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    assign zero = (value == 16'h0000);

endmodule

// File: rtl/charge_countdown_ctrl.sv
// Charge-time sequencer: loads a BCD time, counts it down once per second,
// runs the end-of-charge buzzer window and blanks the display when idle.
//
// start, abort and wake are single-cycle request pulses with no handshake:
// each is acted on in the cycle it is high and never held or queued.
// Within one cycle abort outranks the one-second tick, which outranks start.
module charge_countdown_ctrl
    import charge_pkg::*;
#(
    parameter int TICK_DIV  = 500,
    parameter int ALARM_SEC = 3,
    parameter int SLEEP_SEC = 10
) (
    input  logic        clk,
    input  logic        rd,
    input  logic        start,
    input  logic [15:0] load_bcd,
    input  logic        abort,
    input  logic        wake,
    output logic [15:0] remain_bcd,
    output logic        busy,
    output logic        buzzer_en,
    output logic        done,
    output logic        bi,
    output state_t      dbg_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]    IDLE_LAST  = 8'(SLEEP_SEC - 1);
    localparam logic [7:0]    ALARM_LAST = 8'(ALARM_SEC - 1);

    state_t         state, state_next;
    logic [PW-1:0]  presc;
    logic [7:0]     idle_cnt, idle_next;
    logic [7:0]     alarm_cnt, alarm_next;
    logic           sec_tick;
    logic           ld, dec, done_next, remain_zero;
    logic [15:0]    ld_val;

    assign sec_tick  = (presc == PRE_LAST);
    assign dbg_state = state;

    bcd_down4 u_remain (
        .clk      (clk),
        .rd       (rd),
        .load     (ld),
        .load_val (ld_val),
        .dec      (dec),
        .value    (remain_bcd),
        .zero     (remain_zero)
    );

    // Next-state, countdown control and second-counter updates.
    always_comb begin
        state_next = state;
        ld         = 1'b0;
        ld_val     = BCD_ZERO;
        dec        = 1'b0;
        done_next  = 1'b0;
        idle_next  = idle_cnt;
        alarm_next = alarm_cnt;
        case (state)
            IDLE: begin
                if (sec_tick && idle_cnt == IDLE_LAST) begin
                    state_next = SLEEP;
                end else if (start && bcd_valid(load_bcd) && load_bcd != BCD_ZERO) begin
                    state_next = RUN;
                    ld         = 1'b1;
                    ld_val     = load_bcd;
                end else if (start || wake) begin
                    idle_next = 8'd0;
                end else if (sec_tick) begin
                    idle_next = idle_cnt + 8'd1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    ld         = 1'b1;
                end else if (sec_tick && !remain_zero) begin
                    dec = 1'b1;
                    if (remain_bcd == 16'h0001) begin
                        state_next = ALARM;
                        done_next  = 1'b1;
                    end
                end
            end
            ALARM: begin
                if (abort || wake) begin
                    state_next = IDLE;
                end else if (sec_tick) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_next = IDLE;
                    end else begin
                        alarm_next = alarm_cnt + 8'd1;
                    end
                end
            end
            SLEEP: begin
                if (wake || start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Every state starts with fresh second counters.
        if (state_next != state) begin
            idle_next  = 8'd0;
            alarm_next = 8'd0;
        end
    end

    // State, prescaler (restarted on every state entry), counters, outputs.
    always_ff @(posedge clk or negedge rd) begin
        if (!rd) begin
            state     <= IDLE;
            presc     <= '0;
            idle_cnt  <= 8'd0;
            alarm_cnt <= 8'd0;
            busy      <= 1'b0;
            buzzer_en <= 1'b0;
            done      <= 1'b0;
            bi        <= 1'b1;
        end else begin
            state     <= state_next;
            idle_cnt  <= idle_next;
            alarm_cnt <= alarm_next;
            if (state_next != state || sec_tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            busy      <= (state_next == RUN);
            buzzer_en <= (state_next == ALARM);
            done      <= done_next;
            bi        <= (state_next != SLEEP);
        end
    end

endmodule

// File: tb/tb_charge_countdown_ctrl.sv
// Bench for charge_countdown_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a seconds-level reference model.
module tb_charge_countdown_ctrl;
    import charge_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int ALARM_SEC = 3;
    localparam int SLEEP_SEC = 10;

    logic        clk = 1'b0;
    logic        rd = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wake = 1'b0;
    logic [15:0] load_bcd = 16'h0000;
    logic [15:0] remain_bcd;
    logic        busy, buzzer_en, done, bi;
    state_t      dbg_state;

    charge_countdown_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .ALARM_SEC (ALARM_SEC),
        .SLEEP_SEC (SLEEP_SEC)
    ) dut (
        .clk        (clk),
        .rd         (rd),
        .start      (start),
        .load_bcd   (load_bcd),
        .abort      (abort),
        .wake       (wake),
        .remain_bcd (remain_bcd),
        .busy       (busy),
        .buzzer_en  (buzzer_en),
        .done       (done),
        .bi         (bi),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];

    // reference model: remaining time kept as plain integer seconds
    state_t m_st;
    int     m_sec, m_phase, m_idle, m_alarm;
    bit     m_done;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit load_ok(input logic [15:0] b);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] sh;
            sh = b >> (4 * i);
            if (sh[3:0] > 4'd9) return 1'b0;
        end
        return (b != 16'h0000);
    endfunction

    function automatic logic [21:0] snapshot();
        return {m_st, to_bcd(m_sec), (m_st == RUN), (m_st == ALARM), m_done, (m_st != SLEEP)};
    endfunction

    task automatic model_reset();
        m_st = IDLE; m_sec = 0; m_phase = 0; m_idle = 0; m_alarm = 0; m_done = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step(input bit s, input bit a, input bit w, input logic [15:0] ld);
        bit     tick;
        state_t nxt;
        tick   = (m_phase == TICK_DIV - 1);
        nxt    = m_st;
        m_done = 1'b0;
        case (m_st)
            IDLE: begin
                if (tick && m_idle + 1 == SLEEP_SEC) nxt = SLEEP;
                else if (s && load_ok(ld)) begin nxt = RUN; m_sec = from_bcd(ld); end
                else if (s || w) m_idle = 0;
                else if (tick) m_idle++;
            end
            RUN: begin
                if (a) begin nxt = IDLE; m_sec = 0; end
                else if (tick) begin
                    m_sec--;
                    if (m_sec == 0) begin nxt = ALARM; m_done = 1'b1; end
                end
            end
            ALARM: begin
                if (a || w) nxt = IDLE;
                else if (tick) begin
                    m_alarm++;
                    if (m_alarm == ALARM_SEC) nxt = IDLE;
                end
            end
            default: if (s || w) nxt = IDLE;
        endcase
        if (nxt != m_st) begin
            m_phase = 0; m_idle = 0; m_alarm = 0;
        end else begin
            m_phase = (m_phase + 1) % TICK_DIV;
        end
        m_st = nxt;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // driver: called at a falling edge, drives one cycle of inputs
    task automatic drive(input bit s, input bit a, input bit w, input logic [15:0] ld);
        start = s; abort = a; wake = w; load_bcd = ld;
        @(posedge clk);
        model_step(s, a, w, ld);
        exp_q.push_back(snapshot());
        @(negedge clk);
        start = 1'b0; abort = 1'b0; wake = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // scoreboard monitor: one expected snapshot per clock edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [21:0] e, g;
            e = exp_q.pop_front();
            g = {dbg_state, remain_bcd, busy, buzzer_en, done, bi};
            check("outputs{st,rem,busy,buz,done,bi}", 32'(g), 32'(e));
        end
    end

    initial begin
        model_reset();
        // power-on reset
        #2 rd = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_remain", 32'(remain_bcd), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_buzzer", 32'(buzzer_en), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_bi", 32'(bi), 32'h1);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rd = 1'b1;

        // asynchronous reset in the middle of a countdown
        drive(1'b1, 1'b0, 1'b0, 16'h0012);
        idle_cycles(20);
        #2 rd = 1'b0;
        #1;
        check("midrun_reset_remain", 32'(remain_bcd), 32'h0);
        check("midrun_reset_busy", 32'(busy), 32'h0);
        check("midrun_reset_bi", 32'(bi), 32'h1);
        check("midrun_reset_state", 32'(dbg_state), 32'(IDLE));
        model_reset();
        @(negedge clk);
        rd = 1'b1;

        // full countdown from 3 through the alarm window back to IDLE
        drive(1'b1, 1'b0, 1'b0, 16'h0003);
        idle_cycles(30);

        // borrow across digits
        drive(1'b1, 1'b0, 1'b0, 16'h1000);
        idle_cycles(6);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0100);
        idle_cycles(6);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);

        // abort after two ticks, then abort on the final tick
        drive(1'b1, 1'b0, 1'b0, 16'h0050);
        idle_cycles(9);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        idle_cycles(3);
        drive(1'b1, 1'b0, 1'b0, 16'h0001);
        idle_cycles(3);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        idle_cycles(6);

        // invalid and zero loads are ignored
        drive(1'b1, 1'b0, 1'b0, 16'h00A5);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h9F00);
        idle_cycles(2);

        // sleep, wake with start (no load), then a real start
        idle_cycles(45);
        drive(1'b1, 1'b0, 1'b0, 16'h0005);
        idle_cycles(2);
        drive(1'b1, 1'b0, 1'b0, 16'h0005);
        idle_cycles(10);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        idle_cycles(3);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit          s, a, w;
            logic [15:0] ld;
            s = ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
                0:       ld = to_bcd($urandom_range(1, 6));
                1:       ld = to_bcd($urandom_range(0, 9999));
                2:       ld = 16'($urandom);
                default: ld = 16'h0000;
            endcase
            drive(s, a, w, ld);
        end

        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
